serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised bit-serial successor to the single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock, through one registered full-adder cell.
- Uses a start/busy/done handshake.
- Used where area matters more than latency, e.g. small datapaths and checksum accumulation.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A; captured at start
- b  input  WIDTH  operand B; captured at start
- cin  input  1  carry-in; captured at start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: result valid
- s  output  WIDTH  sum; held until the next completion
- cout  output  1  carry-out; held with s

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst_n is asynchronous, active-low.
  - Reset values: busy=0, done=0, s=0, cout=0, state=IDLE, counter=0, all internal shift and carry registers 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 captures a, b, cin into shift registers and the carry flop.
  - Moves to RUN; busy=1 from E0.
- RUN:
  - Each edge adds bit 0 of the A/B shift registers and the carry flop.
  - Shifts A/B right by one.
  - Shifts the sum bit into the MSB of the sum shift register.
  - Updates carry; increments the counter.
  - At edge E_WIDTH (last bit):
    - sum shift register → s; final carry → cout.
    - busy=0, done=1, state=DONE.
- DONE:
  - done high for exactly one cycle.
  - If start=1 at the next edge, new operands are captured and state goes straight to RUN (back-to-back, no idle bubble); done drops.
  - Otherwise state goes to IDLE.
- Latency: done is visible exactly WIDTH cycles after the start edge. Throughput: one add per WIDTH+1 cycles.
- start while busy=1: ignored; operands are not re-captured; current operation is unaffected.
- s and cout change only at completion edges.
- Inputs a/b/cin may change freely after the capture edge.
- Counter is $clog2(WIDTH) bits and resets to 0 at every capture.
- No wrap beyond WIDTH-1.
- Reset mid-operation: immediate abort; all outputs return to reset values; no done pulse.
- Arithmetic is unsigned: {cout,s} = a + b + cin, modulo 2^(WIDTH+1) exact.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - ovf = carry into MSB XOR carry out of MSB, i.e. two's-complement signed overflow.
  - Registered at the completion edge alongside s and cout; held until the next completion.
- Undefined: no ovf port and no extra logic. Everything else is identical.

Decomposition:
- Shared package serial_adder_pkg:
  - state enum typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Function for counter width: clog2 of WIDTH, minimum 1.
- One natural sub-module: fa_cell, a purely combinational full adder (a, b, cin → s, cout). It is instantiated once and its carry is registered by the parent.

Test Plan (WIDTH=8):
- Reset check: assert rst_n=0 asynchronously, mid-cycle → busy=0, done=0, s=0x00, cout=0 immediately, without waiting for a clock edge.
- Basic add: a=0x35, b=0x4A, cin=0, start pulsed → done exactly 8 cycles after the start edge; s=0x7F, cout=0; busy high for those 8 cycles.
- Full wrap: a=0xFF, b=0x01, cin=0 → s=0x00, cout=1.
  - With SERIAL_ADDER_OVF_EN, ovf=0.
  - Also a=0x7F, b=0x01 → s=0x80, cout=0, ovf=1.
- Carry-in and max: a=0xFF, b=0xFF, cin=1 → s=0xFF, cout=1.
- Handshake edges:
  - start held high through RUN with a/b changed mid-run → result reflects originally captured operands.
  - start=1 during the done cycle with a=0x01, b=0x02 → second done exactly 8 cycles later; s=0x03.
- Reset mid-operation: rst_n low at cycle 4 of RUN → no done pulse; outputs 0.
  - After release, a=0x10, b=0x20 → s=0x30, cout=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-counter width; never below one bit so the counter always exists.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Purely combinational single-bit full adder; the serial adder registers its carry.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through a single full-adder cell.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Only WIDTH-1 partial sum bits are ever stored; the final bit joins them at completion.
    logic [WIDTH-1:1] sum_q, sum_d, sum_shift;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_s;
    logic fa_cout;

    fa_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH - 1; gi++) begin : g_sum_shift
            assign sum_shift[gi] = sum_q[gi+1];
        end
    endgenerate
    assign sum_shift[WIDTH-1] = fa_s;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = sum_shift;
                carry_d = fa_cout;
                if (cnt_q == LAST_BIT) begin
                    // Counter holds here rather than wrapping; the next capture clears it.
                    s_d     = {fa_s, sum_q};
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_cout;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic         cout;
    logic [W-1:0] s;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned and signed integer arithmetic.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int unsigned r;
        r = int'(x) + int'(y) + int'(c);
        return r[W:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int r;
        r = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (r > 127) || (r < -128);
    endfunction

    // Drives operands with start high across one rising edge (the capture edge E0).
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit hold);
        a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
    endtask

    // Counts cycles after E0 until done; -1 on timeout. Also counts cycles where busy dropped early.
    task automatic wait_done(output int cyc, output int drops);
        bit seen;
        seen = 0; cyc = 0; drops = 0;
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (done) seen = 1;
            else if (!busy) drops++;
        end
        if (!seen) cyc = -1;
    endtask

    task automatic test_reset();
        int cyc, drops;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || s !== 8'h00 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b s=%h cout=%b expected 0 0 00 0", busy, done, s, cout);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        launch(8'h35, 8'h4A, 1'b0, 0);
        wait_done(cyc, drops);
        @(negedge clk);
        launch(8'h11, 8'h22, 1'b0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || s !== 8'h00 || cout !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b s=%h cout=%b expected 0 0 00 0", busy, done, s, cout);
        end
        $display("reset: async assert mid-cycle busy=%b s=%h", busy, s);
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add_vector(input string name, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int cyc, drops;
        logic [W:0] exp;
        exp = ref_sum(x, y, c);
        @(negedge clk);
        launch(x, y, c, 0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_at_start: busy=%b done=%b expected 1 0", name, busy, done);
        end
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        wait_done(cyc, drops);
        checks++;
        if (cyc !== 8 || drops !== 0) begin
            errors++;
            $display("FAIL %s_latency: cycles=%0d busy_gaps=%0d expected 8 0", name, cyc, drops);
        end
        checks++;
        if (s !== exp[W-1:0] || cout !== exp[W]) begin
            errors++;
            $display("FAIL %s_sum: s=%h cout=%b expected s=%h cout=%b", name, s, cout, exp[W-1:0], exp[W]);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (ovf !== ref_ovf(x, y, c)) begin
            errors++;
            $display("FAIL %s_ovf: ovf=%b expected %b", name, ovf, ref_ovf(x, y, c));
        end
`endif
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || s !== exp[W-1:0] || cout !== exp[W]) begin
            errors++;
            $display("FAIL %s_after_done: done=%b busy=%b s=%h cout=%b expected 0 0 %h %b",
                     name, done, busy, s, cout, exp[W-1:0], exp[W]);
        end
        $display("%s: %h + %h + %b -> s=%h cout=%b cycles=%0d", name, x, y, c, s, cout, cyc);
    endtask

    task automatic test_start_held();
        int cyc;
        logic [W:0] exp;
        exp = ref_sum(8'h5C, 8'h27, 1'b1);
        @(negedge clk);
        launch(8'h5C, 8'h27, 1'b1, 1);
        cyc = 0;
        while (!done && cyc < 20) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (cyc !== 8 || s !== exp[W-1:0] || cout !== exp[W]) begin
            errors++;
            $display("FAIL start_held: cycles=%0d s=%h cout=%b expected 8 %h %b", cyc, s, cout, exp[W-1:0], exp[W]);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_held_idle: busy=%b done=%b expected 0 0", busy, done);
        end
        $display("start_held: s=%h cout=%b cycles=%0d", s, cout, cyc);
    endtask

    task automatic test_back_to_back();
        int cyc, drops;
        logic [W:0] exp1;
        exp1 = ref_sum(8'hC3, 8'h99, 1'b1);
        @(negedge clk);
        launch(8'hC3, 8'h99, 1'b1, 0);
        wait_done(cyc, drops);
        checks++;
        if (cyc !== 8 || s !== exp1[W-1:0] || cout !== exp1[W]) begin
            errors++;
            $display("FAIL b2b_first: cycles=%0d s=%h cout=%b expected 8 %h %b", cyc, s, cout, exp1[W-1:0], exp1[W]);
        end
        launch(8'h01, 8'h02, 1'b0, 0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || s !== exp1[W-1:0] || cout !== exp1[W]) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b done=%b s=%h cout=%b expected 1 0 %h %b",
                     busy, done, s, cout, exp1[W-1:0], exp1[W]);
        end
        wait_done(cyc, drops);
        checks++;
        if (cyc !== 8 || drops !== 0 || s !== 8'h03 || cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: cycles=%0d gaps=%0d s=%h cout=%b expected 8 0 03 0", cyc, drops, s, cout);
        end
        $display("back_to_back: second s=%h cycles=%0d", s, cyc);
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        launch(8'hE7, 8'h6B, 1'b1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || s !== 8'h00 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b s=%h cout=%b expected 0 0 00 0", busy, done, s, cout);
        end
        pulses = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: done pulses=%0d expected 0", pulses);
        end
        $display("reset_mid: aborted, done pulses=%0d", pulses);
        test_add_vector("post_reset", 8'h10, 8'h20, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        logic c;
        for (int i = 0; i < 30; i++) begin
            x = W'($urandom); y = W'($urandom); c = 1'($urandom);
            test_add_vector("random", x, y, c);
        end
    endtask

    initial begin
        test_reset();
        test_add_vector("basic", 8'h35, 8'h4A, 1'b0);
        test_add_vector("wrap", 8'hFF, 8'h01, 1'b0);
        test_add_vector("signed_ovf", 8'h7F, 8'h01, 1'b0);
        test_add_vector("cin_max", 8'hFF, 8'hFF, 1'b1);
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
